// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point operand alignment pipeline.
//  - GRS_W      : number of guard/round/sticky bits appended below the mantissa
//  - op_w()     : IEEE operand width from exponent/mantissa field widths
//  - sig_w()    : aligned significand width (hidden + mantissa + G,R,S)
//  - a_flags_t  : per-pair flag payload carried from stage A into stage B
//  - FP_SIGN / FP_EXP / FP_MAN : field-slice macros for a packed IEEE operand
// Optional feature macro: FP_ALIGN_SPECIAL_EN adds NaN/Inf flags to the payload.

`ifndef FP_PKG_MACROS
`define FP_PKG_MACROS
`define FP_SIGN(v, ew, mw) v[(ew)+(mw)]
`define FP_EXP(v, ew, mw)  v[(ew)+(mw)-1 -: (ew)]
`define FP_MAN(v, ew, mw)  v[(mw)-1:0]
`endif

package fp_pkg;

   localparam int GRS_W = 3;

   function automatic int op_w(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   function automatic int sig_w(input int man_w);
      return 1 + man_w + GRS_W;
   endfunction

   typedef struct packed {
      logic eff_sub;
`ifdef FP_ALIGN_SPECIAL_EN
      logic is_nan;
      logic is_inf;
`endif
   } a_flags_t;

endpackage

// File: rtl/fp_align_pipe_if.sv
// Handshake and data bundle of the alignment pipeline.
//  master : producer/consumer side (drives X/Y/in_valid and out_ready)
//  slave  : the pipeline itself (drives in_ready and all result fields)
// Optional feature macro: FP_ALIGN_SPECIAL_EN adds out_nan / out_inf.

interface fp_align_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   import fp_pkg::*;

   localparam int W     = op_w(EXP_W, MAN_W);
   localparam int SIG_W = sig_w(MAN_W);

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     X;
   logic [W-1:0]     Y;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     outB;
   logic [W-1:0]     outL;
   logic [EXP_W-1:0] dif;
   logic [SIG_W-1:0] big_sig;
   logic [SIG_W-1:0] lit_sig;
   logic             eff_sub;
`ifdef FP_ALIGN_SPECIAL_EN
   logic             out_nan;
   logic             out_inf;
`endif

   modport master (
      output in_valid, X, Y, out_ready,
`ifdef FP_ALIGN_SPECIAL_EN
      input  out_nan, out_inf,
`endif
      input  in_ready, out_valid, outB, outL, dif, big_sig, lit_sig, eff_sub
   );

   modport slave (
      input  in_valid, X, Y, out_ready,
`ifdef FP_ALIGN_SPECIAL_EN
      output out_nan, out_inf,
`endif
      output in_ready, out_valid, outB, outL, dif, big_sig, lit_sig, eff_sub
   );

endinterface

// File: rtl/fp_rshift_sticky.sv
// Combinational right shifter for the little significand.
//  sig_in  : {hidden, mantissa, G,R,S} before alignment
//  sh      : shift amount (exponent difference)
//  sig_out : sig_in >> sh with every shifted-out bit (and the original bit0)
//            folded into bit0; shifts of SIG_W or more collapse to {0..0, |sig_in}

module fp_rshift_sticky
   import fp_pkg::*;
#(
   parameter int SIG_W = 27,
   parameter int EXP_W = 8
) (
   input  logic [SIG_W-1:0] sig_in,
   input  logic [EXP_W-1:0] sh,
   output logic [SIG_W-1:0] sig_out
);

   logic [SIG_W-1:0] shifted;
   logic [SIG_W-1:0] lost_mask;
   logic             sticky;

   // Barrel shift with sticky collection and saturation for oversized shifts
   always_comb begin
      shifted   = sig_in >> sh;
      lost_mask = ~({SIG_W{1'b1}} << sh);
      sticky    = 1'b0;
      sig_out   = {SIG_W{1'b0}};
      if (32'(sh) >= 32'(SIG_W)) begin
         sticky  = |sig_in;
         sig_out = {{(SIG_W-1){1'b0}}, sticky};
      end else begin
         sticky  = (|(sig_in & lost_mask)) | sig_in[0];
         sig_out = {shifted[SIG_W-1:1], shifted[0] | sticky};
      end
   end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage valid/ready pipeline that orders an IEEE operand pair by magnitude
// and aligns the smaller significand to the larger one.
//  clk, rst : clock and synchronous active-high reset
//  bus      : fp_align_pipe_if.slave
//             in_valid/in_ready/X/Y   operand pair handshake
//             out_valid/out_ready     result handshake
//             outB/outL               big/little operand, unmodified
//             dif                     exponent difference (>= 0)
//             big_sig/lit_sig         big significand, aligned little significand
//             eff_sub                 operand signs differ
// Stage A registers the ordering, exponent difference and flags; stage B
// registers the shifted little significand. No skid buffer: in_ready is
// combinational from stage occupancy and out_ready.
// Optional feature macro: FP_ALIGN_SPECIAL_EN adds out_nan / out_inf.

module fp_align_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic          clk,
   input  logic          rst,
   fp_align_pipe_if.slave bus
);

   localparam int W     = op_w(EXP_W, MAN_W);
   localparam int SIG_W = sig_w(MAN_W);
   localparam int MAG_W = EXP_W + MAN_W;

   logic             a_vld;
   logic             b_adv;
   logic [W-1:0]     a_big;
   logic [W-1:0]     a_lit;
   logic [EXP_W-1:0] a_dif;
   a_flags_t         a_flags;

   logic             y_bigger;
   logic [W-1:0]     cmp_big;
   logic [W-1:0]     cmp_lit;
   logic [EXP_W-1:0] cmp_dif;
   a_flags_t         cmp_flags;

   logic [SIG_W-1:0] lit_pre;
   logic [SIG_W-1:0] lit_shifted;

`ifdef FP_ALIGN_SPECIAL_EN
   function automatic logic op_nan(input logic [W-1:0] v);
      return (&`FP_EXP(v, EXP_W, MAN_W)) & (|`FP_MAN(v, EXP_W, MAN_W));
   endfunction

   function automatic logic op_inf(input logic [W-1:0] v);
      return (&`FP_EXP(v, EXP_W, MAN_W)) & ~(|`FP_MAN(v, EXP_W, MAN_W));
   endfunction

   logic inf_cancel;
`endif

   // Handshake: stage B frees when empty or drained; stage A frees when empty or moving on
   always_comb begin
      b_adv        = ~bus.out_valid | bus.out_ready;
      bus.in_ready = ~a_vld | b_adv;
   end

   // Magnitude ordering (sign ignored, tie keeps X big) and stage-A flags
   always_comb begin
      y_bigger  = bus.Y[MAG_W-1:0] > bus.X[MAG_W-1:0];
      cmp_flags = '0;
      if (y_bigger) begin
         cmp_big = bus.Y;
         cmp_lit = bus.X;
      end else begin
         cmp_big = bus.X;
         cmp_lit = bus.Y;
      end
      cmp_dif = `FP_EXP(cmp_big, EXP_W, MAN_W) - `FP_EXP(cmp_lit, EXP_W, MAN_W);
      cmp_flags.eff_sub = `FP_SIGN(bus.X, EXP_W, MAN_W) ^ `FP_SIGN(bus.Y, EXP_W, MAN_W);
`ifdef FP_ALIGN_SPECIAL_EN
      // Opposite-signed infinities cancel to an invalid result, reported as NaN
      inf_cancel = op_inf(bus.X) & op_inf(bus.Y) & cmp_flags.eff_sub;
      cmp_flags.is_nan = op_nan(bus.X) | op_nan(bus.Y) | inf_cancel;
      cmp_flags.is_inf = (op_inf(bus.X) | op_inf(bus.Y)) & ~cmp_flags.is_nan;
`endif
   end

   // Stage A register: captures an accepted pair
   always_ff @(posedge clk) begin
      if (rst) begin
         a_vld   <= 1'b0;
         a_big   <= {W{1'b0}};
         a_lit   <= {W{1'b0}};
         a_dif   <= {EXP_W{1'b0}};
         a_flags <= '0;
      end else if (bus.in_ready) begin
         a_vld <= bus.in_valid;
         if (bus.in_valid) begin
            a_big   <= cmp_big;
            a_lit   <= cmp_lit;
            a_dif   <= cmp_dif;
            a_flags <= cmp_flags;
         end
      end
   end

   // Little significand with implicit bit (zero for subnormals) and cleared G,R,S
   always_comb begin
      lit_pre = {|`FP_EXP(a_lit, EXP_W, MAN_W), `FP_MAN(a_lit, EXP_W, MAN_W), {GRS_W{1'b0}}};
   end

   fp_rshift_sticky #(
      .SIG_W (SIG_W),
      .EXP_W (EXP_W)
   ) u_rshift (
      .sig_in  (lit_pre),
      .sh      (a_dif),
      .sig_out (lit_shifted)
   );

   // Stage B register: result fields, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.outB      <= {W{1'b0}};
         bus.outL      <= {W{1'b0}};
         bus.dif       <= {EXP_W{1'b0}};
         bus.big_sig   <= {SIG_W{1'b0}};
         bus.lit_sig   <= {SIG_W{1'b0}};
         bus.eff_sub   <= 1'b0;
`ifdef FP_ALIGN_SPECIAL_EN
         bus.out_nan   <= 1'b0;
         bus.out_inf   <= 1'b0;
`endif
      end else if (b_adv) begin
         bus.out_valid <= a_vld;
         if (a_vld) begin
            bus.outB    <= a_big;
            bus.outL    <= a_lit;
            bus.dif     <= a_dif;
            bus.big_sig <= {|`FP_EXP(a_big, EXP_W, MAN_W), `FP_MAN(a_big, EXP_W, MAN_W), {GRS_W{1'b0}}};
            bus.lit_sig <= lit_shifted;
            bus.eff_sub <= a_flags.eff_sub;
`ifdef FP_ALIGN_SPECIAL_EN
            bus.out_nan <= a_flags.is_nan;
            bus.out_inf <= a_flags.is_inf;
`endif
         end
      end
   end

endmodule
